// File: rtl/tlc_pkg.sv
// Shared constants for the four-way traffic light controller: road
// encoding and default green-time timing values.
package tlc_pkg;

    // Road encoding used by next_road and the per-road register arrays.
    localparam logic [1:0] ROAD_N = 2'd0;
    localparam logic [1:0] ROAD_E = 2'd1;
    localparam logic [1:0] ROAD_S = 2'd2;
    localparam logic [1:0] ROAD_W = 2'd3;

    // Number of roads served by the controller.
    localparam int unsigned NUM_ROADS = 4;

    // Default green-time timing, in ticks.
    localparam logic [7:0]  MIN_GREEN_DEF = 8'd10;
    localparam logic [7:0]  MAX_GREEN_DEF = 8'd60;
    localparam int unsigned SHIFT_DEF     = 2;

endpackage : tlc_pkg

// File: rtl/green_time_calc.sv
// Combinational green-time calculation: scales a vehicle count down by
// 2^SHIFT, adds the minimum green time and saturates at MAX_GREEN.
// The sum is formed in 9 bits so nothing wraps before the clamp.
module green_time_calc
    import tlc_pkg::*;
#(
    parameter logic [7:0]  MIN_GREEN = MIN_GREEN_DEF,
    parameter logic [7:0]  MAX_GREEN = MAX_GREEN_DEF,
    parameter int unsigned SHIFT     = SHIFT_DEF
) (
    input  logic [7:0] count,
    output logic [7:0] green_time
);

    logic [7:0] scaled_s;
    logic [8:0] sum_s;

    // Form the widened sum and clamp it to the ceiling.
    always_comb begin
        scaled_s   = count >> SHIFT;
        sum_s      = {1'b0, MIN_GREEN} + {1'b0, scaled_s};
        green_time = MIN_GREEN;
        if (sum_s > {1'b0, MAX_GREEN}) begin
            green_time = MAX_GREEN;
        end else begin
            green_time = sum_s[7:0];
        end
    end

endmodule : green_time_calc

// File: rtl/adaptation_sensor_unit.sv
// Per-road adaptive green-time unit. Captures the sensor count for the
// road about to receive green, either on the first edge after reset or
// whenever next_road changes, and keeps a count and a saturated green
// time per road. All outputs come straight from registers.
module adaptation_sensor_unit
    import tlc_pkg::*;
#(
    parameter logic [7:0]  MIN_GREEN = MIN_GREEN_DEF,
    parameter logic [7:0]  MAX_GREEN = MAX_GREEN_DEF,
    parameter int unsigned SHIFT     = SHIFT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] next_road,
    input  logic [7:0] data_in,
    output logic [7:0] N_n,
    output logic [7:0] N_e,
    output logic [7:0] N_s,
    output logic [7:0] N_w,
    output logic [7:0] TGn,
    output logic [7:0] TGe,
    output logic [7:0] TGs,
    output logic [7:0] TGw
);

    logic [7:0] cnt_r [NUM_ROADS];
    logic [7:0] tg_r  [NUM_ROADS];
    logic [1:0] prev_road_r;
    logic       armed_r;
    logic       capture_s;
    logic [7:0] green_time_s;

    // Single shared calculator working on the live sensor value.
    green_time_calc #(
        .MIN_GREEN (MIN_GREEN),
        .MAX_GREEN (MAX_GREEN),
        .SHIFT     (SHIFT)
    ) u_green_time_calc (
        .count      (data_in),
        .green_time (green_time_s)
    );

    // Decide whether this edge captures: first edge after reset or a road change.
    always_comb begin
        capture_s = 1'b0;
        if (!armed_r) begin
            capture_s = 1'b1;
        end else if (next_road != prev_road_r) begin
            capture_s = 1'b1;
        end else begin
            capture_s = 1'b0;
        end
    end

    // Per-road count/time storage plus the change-detection state.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ROADS; i++) begin
                cnt_r[i] <= 8'd0;
                tg_r[i]  <= MIN_GREEN;
            end
            prev_road_r <= ROAD_N;
            armed_r     <= 1'b0;
        end else if (capture_s) begin
            cnt_r[next_road] <= data_in;
            tg_r[next_road]  <= green_time_s;
            prev_road_r      <= next_road;
            armed_r          <= 1'b1;
        end else begin
            prev_road_r <= prev_road_r;
            armed_r     <= armed_r;
        end
    end

    assign N_n = cnt_r[ROAD_N];
    assign N_e = cnt_r[ROAD_E];
    assign N_s = cnt_r[ROAD_S];
    assign N_w = cnt_r[ROAD_W];
    assign TGn = tg_r[ROAD_N];
    assign TGe = tg_r[ROAD_E];
    assign TGs = tg_r[ROAD_S];
    assign TGw = tg_r[ROAD_W];

endmodule : adaptation_sensor_unit

// File: tb/tb_adaptation_sensor_unit.sv
// Self-checking bench for adaptation_sensor_unit: directed scenarios
// followed by randomized road/count/reset traffic, all compared against
// a behavioural model of the capture and green-time rules.
module tb_adaptation_sensor_unit;

    localparam int MIN_G = 10;
    localparam int MAX_G = 60;
    localparam int SHF   = 2;

    logic       clk;
    logic       reset;
    logic [1:0] next_road;
    logic [7:0] data_in;
    logic [7:0] N_n, N_e, N_s, N_w;
    logic [7:0] TGn, TGe, TGs, TGw;

    int vectors;
    int miscompares;

    // Reference model state
    int  m_cnt [4];
    int  m_tg  [4];
    int  m_prev;
    bit  m_armed;

    adaptation_sensor_unit dut (
        .clk       (clk),
        .reset     (reset),
        .next_road (next_road),
        .data_in   (data_in),
        .N_n       (N_n),
        .N_e       (N_e),
        .N_s       (N_s),
        .N_w       (N_w),
        .TGn       (TGn),
        .TGe       (TGe),
        .TGs       (TGs),
        .TGw       (TGw)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_green(input int cnt);
        int t;
        t = MIN_G + cnt / (1 << SHF);
        if (t > MAX_G) t = MAX_G;
        return t;
    endfunction

    function automatic logic [7:0] obs_cnt(input int r);
        case (r)
            0: return N_n;
            1: return N_e;
            2: return N_s;
            default: return N_w;
        endcase
    endfunction

    function automatic logic [7:0] obs_tg(input int r);
        case (r)
            0: return TGn;
            1: return TGe;
            2: return TGs;
            default: return TGw;
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0;
            m_tg[i]  = MIN_G;
        end
        m_prev  = 0;
        m_armed = 1'b0;
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("N[%0d]", i), obs_cnt(i), 8'(m_cnt[i]));
            check_val($sformatf("TG[%0d]", i), obs_tg(i), 8'(m_tg[i]));
        end
    endtask

    // Apply one edge with the given inputs, advance the model, then check.
    task automatic step(input logic r, input logic [1:0] road, input logic [7:0] d);
        reset     = r;
        next_road = road;
        data_in   = d;
        @(posedge clk);
        if (r) begin
            model_clear();
        end else if (!m_armed || int'(road) != m_prev) begin
            m_cnt[road] = int'(d);
            m_tg[road]  = model_green(int'(d));
            m_prev      = int'(road);
            m_armed     = 1'b1;
        end
        #1;
        check_all();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        next_road   = 2'd0;
        data_in     = 8'd0;
        model_clear();

        // Reset held
        step(1'b1, 2'd0, 8'd55);
        step(1'b1, 2'd2, 8'd99);
        check_val("rst_tgs", TGs, 8'd10);

        // First capture after release, road 0
        step(1'b0, 2'd0, 8'd100);
        check_val("first_nn", N_n, 8'd100);
        check_val("first_tgn", TGn, 8'd35);
        check_val("first_tge", TGe, 8'd10);

        step(1'b0, 2'd1, 8'd200);
        check_val("sat_tge", TGe, 8'd60);
        step(1'b0, 2'd2, 8'd150);
        check_val("tgs_47", TGs, 8'd47);
        step(1'b0, 2'd3, 8'd240);
        check_val("sat_tgw", TGw, 8'd60);

        // Hold road 3 while data changes
        step(1'b0, 2'd3, 8'd190);
        check_val("hold_nw", N_w, 8'd240);
        step(1'b0, 2'd3, 8'd7);
        check_val("hold_nw2", N_w, 8'd240);

        // Revisit East
        step(1'b0, 2'd1, 8'd190);
        check_val("revisit_ne", N_e, 8'd190);
        check_val("revisit_tge", TGe, 8'd57);
        check_val("revisit_ns", N_s, 8'd150);

        // Zero and near-wrap counts
        step(1'b0, 2'd0, 8'd0);
        check_val("zero_tgn", TGn, 8'd10);
        step(1'b0, 2'd2, 8'd228);
        check_val("nowrap_tgs", TGs, 8'd60);
        step(1'b0, 2'd3, 8'd255);
        check_val("max_tgw", TGw, 8'd60);

        // Reset while road changes, then fresh capture on same road
        step(1'b1, 2'd1, 8'd80);
        check_val("midrst_ne", N_e, 8'd0);
        step(1'b0, 2'd1, 8'd80);
        check_val("postrst_ne", N_e, 8'd80);
        check_val("postrst_tge", TGe, 8'd30);
        step(1'b1, 2'd1, 8'd80);
        step(1'b0, 2'd0, 8'd44);
        check_val("postrst_road0", N_n, 8'd44);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            logic       r;
            logic [1:0] rd;
            logic [7:0] d;
            r  = ($urandom_range(0, 29) == 0);
            rd = ($urandom_range(0, 2) == 0) ? next_road : 2'($urandom_range(0, 3));
            d  = 8'($urandom_range(0, 255));
            step(r, rd, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_adaptation_sensor_unit
